io_bridge: RTL and testbench

Parametrised system bridge between the CPU memory stage and up to eight memory-mapped peripherals, the successor to the fixed two-timer bridge. It decodes word addresses into per-device windows, gates writes by byte-enables, returns device read data with a one-cycle registered read path and a stall handshake, and captures the first illegal access for software inspection. It also synchronises device interrupt lines into a registered hardware-interrupt vector for CP0.

---
 rtl/io_bridge_if.sv | 23 ++
 rtl/io_bridge.sv | 144 ++++++++++++++
 tb/tb_io_bridge.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bridge_if.sv
// CPU-side bus between the memory stage and the peripheral bridge.
// The CPU drives the request fields; the bridge answers with read data,
// a stall handshake and a same-cycle error flag.
interface io_bridge_if;
    logic [31:0] pr_addr;
    logic        pr_we;
    logic        pr_re;
    logic [31:0] pr_wd;
    logic [3:0]  pr_be;
    logic [31:0] pr_rd;
    logic        pr_stall;
    logic        pr_err;

    modport master (
        output pr_addr, pr_we, pr_re, pr_wd, pr_be,
        input  pr_rd, pr_stall, pr_err
    );

    modport slave (
        input  pr_addr, pr_we, pr_re, pr_wd, pr_be,
        output pr_rd, pr_stall, pr_err
    );
endinterface

// File: rtl/io_bridge.sv
// System bridge from the CPU memory stage to up to eight memory-mapped
// peripherals. Each device owns a window of WIN_BYTES bytes starting at
// BASE + i*STRIDE. Writes complete in the request cycle, reads take one
// stall cycle and return registered data. The first illegal access is held
// for software, and device interrupt levels are registered for CP0.
module io_bridge #(
    parameter int unsigned N_DEV     = 2,
    parameter logic [31:0] BASE      = 32'h0000_7f00,
    parameter logic [31:0] STRIDE    = 32'h10,
    parameter int unsigned WIN_BYTES = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    io_bridge_if.slave            pr,
    output logic [31:0]           dev_addr,
    output logic [31:0]           dev_wd,
    output logic [N_DEV-1:0]      dev_we,
    input  logic [32*N_DEV-1:0]   dev_rd,
    input  logic [N_DEV-1:0]      dev_irq,
    output logic [N_DEV-1:0]      hw_int,
    output logic                  err_valid,
    output logic [31:0]           err_addr,
    input  logic                  err_clr
);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        rd_q, rd_d;
    logic               err_valid_q, err_valid_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic [N_DEV-1:0]   hw_int_q, hw_int_d;

    logic [N_DEV-1:0]   hit;
    logic               any_hit;
    logic               illegal;
    logic               rd_ok;
    logic               wr_ok;
    logic [31:0]        rd_sel;

    assign dev_addr = {pr.pr_addr[31:2], 2'b00};
    assign dev_wd   = pr.pr_wd;

    // Window decode: windows never overlap, so at most one hit bit is set.
    for (genvar i = 0; i < int'(N_DEV); i++) begin : g_dec
        localparam logic [31:0] WIN_LO = BASE + 32'(i) * STRIDE;
        localparam logic [31:0] WIN_HI = WIN_LO + 32'(WIN_BYTES) - 32'd1;
        assign hit[i] = (dev_addr >= WIN_LO) && (dev_addr <= WIN_HI);
    end

    assign any_hit = |hit;

    // Classify the current request: conflicting strobes, unmapped address,
    // or a partial write all make it illegal.
    always_comb begin
        illegal = 1'b0;
        if (pr.pr_we && pr.pr_re) begin
            illegal = 1'b1;
        end
        if ((pr.pr_we || pr.pr_re) && !any_hit) begin
            illegal = 1'b1;
        end
        if (pr.pr_we && (pr.pr_be != 4'hF)) begin
            illegal = 1'b1;
        end
        rd_ok = pr.pr_re && !illegal;
        wr_ok = pr.pr_we && !illegal;
    end

    // Read-data mux selecting the slice of the device that was hit.
    always_comb begin
        rd_sel = 32'h0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            if (hit[i]) begin
                rd_sel = dev_rd[32*i +: 32];
            end
        end
    end

    // Next-state logic for the read FSM, error capture and interrupt sync.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        hw_int_d    = dev_irq;

        case (state_q)
            IDLE: begin
                if (rd_ok) begin
                    state_d = RESP;
                    rd_d    = rd_sel;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = 32'h0;
        end else if (illegal && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = pr.pr_addr;
        end
    end

    // All bridge state, cleared synchronously by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_q        <= 32'h0;
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
            hw_int_q    <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            hw_int_q    <= hw_int_d;
        end
    end

    // CPU-facing outputs; combinational ones are held low during reset.
    always_comb begin
        pr.pr_stall = !reset && (state_q == IDLE) && rd_ok;
        pr.pr_rd    = (!reset && (state_q == RESP)) ? rd_q : 32'h0;
        pr.pr_err   = !reset && illegal;
        dev_we      = (!reset && wr_ok) ? hit : '0;
    end

    assign hw_int    = hw_int_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: one instance with default windows and one
// with four wider windows. Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, well away from the next edge.
module tb_io_bridge;

    logic        clk;
    logic        reset;

    io_bridge_if bus ();
    io_bridge_if bus4 ();

    logic [31:0] dev_addr, dev_wd;
    logic [1:0]  dev_we;
    logic [63:0] dev_rd;
    logic [1:0]  dev_irq;
    logic [1:0]  hw_int;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_clr;

    logic [31:0]  dev_addr4, dev_wd4;
    logic [3:0]   dev_we4;
    logic [127:0] dev_rd4;
    logic [3:0]   dev_irq4;
    logic [3:0]   hw_int4;
    logic         err_valid4;
    logic [31:0]  err_addr4;
    logic         err_clr4;

    int checks = 0;
    int errors = 0;

    io_bridge dut (
        .clk      (clk),
        .reset    (reset),
        .pr       (bus.slave),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_we   (dev_we),
        .dev_rd   (dev_rd),
        .dev_irq  (dev_irq),
        .hw_int   (hw_int),
        .err_valid(err_valid),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    io_bridge #(
        .N_DEV    (4),
        .BASE     (32'h0000_7f00),
        .STRIDE   (32'h20),
        .WIN_BYTES(16)
    ) dut4 (
        .clk      (clk),
        .reset    (reset),
        .pr       (bus4.slave),
        .dev_addr (dev_addr4),
        .dev_wd   (dev_wd4),
        .dev_we   (dev_we4),
        .dev_rd   (dev_rd4),
        .dev_irq  (dev_irq4),
        .hw_int   (hw_int4),
        .err_valid(err_valid4),
        .err_addr (err_addr4),
        .err_clr  (err_clr4)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic we,
                                  input logic re, input logic [31:0] wd,
                                  input logic [3:0] be);
        bus.pr_addr = addr;
        bus.pr_we   = we;
        bus.pr_re   = re;
        bus.pr_wd   = wd;
        bus.pr_be   = be;
        #1;
    endtask

    task automatic apply_stimulus4(input logic [31:0] addr, input logic we,
                                   input logic re);
        bus4.pr_addr = addr;
        bus4.pr_we   = we;
        bus4.pr_re   = re;
        bus4.pr_wd   = 32'h0;
        bus4.pr_be   = 4'hF;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset    = 1'b1;
        err_clr  = 1'b0;
        err_clr4 = 1'b0;
        dev_rd   = {32'hCAFE_0001, 32'hD0D0_0000};
        dev_rd4  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        dev_irq  = 2'b00;
        dev_irq4 = 4'h0;
        apply_stimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        apply_stimulus4(32'h0, 1'b0, 1'b0);

        // Reset behaviour: combinational outputs low even with a legal request.
        tick();
        tick();
        apply_stimulus(32'h7f18, 1'b0, 1'b1, 32'h0, 4'hF);
        check_output("rst_stall", 32'(bus.pr_stall), 32'd0);
        check_output("rst_rd", bus.pr_rd, 32'h0);
        apply_stimulus(32'h7f04, 1'b1, 1'b0, 32'h1234, 4'hF);
        check_output("rst_we", 32'(dev_we), 32'd0);
        check_output("rst_err", 32'(bus.pr_err), 32'd0);
        tick();
        check_output("rst_err_valid", 32'(err_valid), 32'd0);
        check_output("rst_err_addr", err_addr, 32'h0);
        check_output("rst_hw_int", 32'(hw_int), 32'd0);
        reset = 1'b0;

        // Legal writes land in the same cycle, byte offsets map to their word.
        apply_stimulus(32'h7f04, 1'b1, 1'b0, 32'h1234, 4'hF);
        check_output("wr0_we", 32'(dev_we), 32'd1);
        check_output("wr0_stall", 32'(bus.pr_stall), 32'd0);
        check_output("wr0_err", 32'(bus.pr_err), 32'd0);
        check_output("wr0_wd", dev_wd, 32'h1234);
        tick();
        apply_stimulus(32'h7f0b, 1'b1, 1'b0, 32'h55, 4'hF);
        check_output("wr_off_addr", dev_addr, 32'h7f08);
        check_output("wr_off_we", 32'(dev_we), 32'd1);
        tick();
        apply_stimulus(32'h7f18, 1'b1, 1'b0, 32'h66, 4'hF);
        check_output("wr1_we", 32'(dev_we), 32'd2);
        tick();

        // Read of device 1: stall in T, data in T+1, then idle again.
        apply_stimulus(32'h7f18, 1'b0, 1'b1, 32'h0, 4'hF);
        check_output("rd1_stall_T", 32'(bus.pr_stall), 32'd1);
        check_output("rd1_rd_T", bus.pr_rd, 32'h0);
        tick();
        check_output("rd1_stall_T1", 32'(bus.pr_stall), 32'd0);
        check_output("rd1_rd_T1", bus.pr_rd, 32'hCAFE_0001);
        apply_stimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        check_output("rd1_idle_rd", bus.pr_rd, 32'h0);
        check_output("rd1_idle_stall", 32'(bus.pr_stall), 32'd0);

        // Read of device 0 at its last word.
        apply_stimulus(32'h7f08, 1'b0, 1'b1, 32'h0, 4'hF);
        check_output("rd0_stall_T", 32'(bus.pr_stall), 32'd1);
        tick();
        check_output("rd0_rd_T1", bus.pr_rd, 32'hD0D0_0000);
        apply_stimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();

        // Gap read is illegal and captured; later errors do not overwrite it.
        apply_stimulus(32'h7f0c, 1'b0, 1'b1, 32'h0, 4'hF);
        check_output("gap_err", 32'(bus.pr_err), 32'd1);
        check_output("gap_stall", 32'(bus.pr_stall), 32'd0);
        check_output("gap_rd", bus.pr_rd, 32'h0);
        tick();
        check_output("gap_err_valid", 32'(err_valid), 32'd1);
        check_output("gap_err_addr", err_addr, 32'h7f0c);
        apply_stimulus(32'h8000, 1'b1, 1'b0, 32'h0, 4'hF);
        check_output("unmapped_wr_err", 32'(bus.pr_err), 32'd1);
        check_output("unmapped_wr_we", 32'(dev_we), 32'd0);
        tick();
        check_output("sticky_err_addr", err_addr, 32'h7f0c);
        apply_stimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_output("clr_err_valid", 32'(err_valid), 32'd0);
        check_output("clr_err_addr", err_addr, 32'h0);

        // Partial write and conflicting strobes are illegal.
        apply_stimulus(32'h7f00, 1'b1, 1'b0, 32'h0, 4'b0011);
        check_output("partial_we", 32'(dev_we), 32'd0);
        check_output("partial_err", 32'(bus.pr_err), 32'd1);
        tick();
        check_output("partial_err_addr", err_addr, 32'h7f00);
        apply_stimulus(32'h7f00, 1'b1, 1'b1, 32'h0, 4'hF);
        err_clr = 1'b1;
        #1;
        check_output("both_err", 32'(bus.pr_err), 32'd1);
        check_output("both_stall", 32'(bus.pr_stall), 32'd0);
        check_output("both_we", 32'(dev_we), 32'd0);
        tick();
        err_clr = 1'b0;
        check_output("clr_prio_valid", 32'(err_valid), 32'd0);
        check_output("clr_prio_addr", err_addr, 32'h0);
        apply_stimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();

        // Reset in the response cycle drops the pending read.
        apply_stimulus(32'h7f18, 1'b0, 1'b1, 32'h0, 4'hF);
        tick();
        check_output("rsp_rd_before_rst", bus.pr_rd, 32'hCAFE_0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        apply_stimulus(32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        check_output("post_rst_rd", bus.pr_rd, 32'h0);
        check_output("post_rst_stall", 32'(bus.pr_stall), 32'd0);
        tick();

        // Interrupt pulse appears on hw_int exactly one cycle later.
        dev_irq = 2'b10;
        #1;
        check_output("irq_lag0", 32'(hw_int), 32'd0);
        tick();
        dev_irq = 2'b00;
        #1;
        check_output("irq_lag1", 32'(hw_int), 32'd2);
        tick();
        check_output("irq_lag2", 32'(hw_int), 32'd0);

        // Four-device configuration with 0x20 stride and 16-byte windows.
        apply_stimulus4(32'h7f6c, 1'b1, 1'b0);
        check_output("d4_wr3_we", 32'(dev_we4), 32'h8);
        check_output("d4_wr3_err", 32'(bus4.pr_err), 32'd0);
        tick();
        apply_stimulus4(32'h7f70, 1'b1, 1'b0);
        check_output("d4_gap_we", 32'(dev_we4), 32'h0);
        check_output("d4_gap_err", 32'(bus4.pr_err), 32'd1);
        tick();
        apply_stimulus4(32'h7f28, 1'b0, 1'b1);
        check_output("d4_rd1_stall", 32'(bus4.pr_stall), 32'd1);
        tick();
        check_output("d4_rd1_data", bus4.pr_rd, 32'h1111_1111);
        apply_stimulus4(32'h0, 1'b0, 1'b0);
        tick();

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
